// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared state, field codes and limits for the clock set controller
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_SET_H = 2'b01,
        ST_SET_M = 2'b10,
        ST_SET_S = 2'b11
    } state_t;

    localparam logic [1:0] FIELD_NONE    = 2'b00;
    localparam logic [1:0] FIELD_HOURS   = 2'b01;
    localparam logic [1:0] FIELD_MINUTES = 2'b10;
    localparam logic [1:0] FIELD_SECONDS = 2'b11;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] HOUR_MAX = 6'd23;

    // Anything at or past the limit rolls to 0, so an out-of-range capture still edits into range.
    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
        return (v >= max) ? 6'd0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides the system clock down to a one-second wrap strobe
module tick_prescaler #(
    parameter int CLK_DIV = 50000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_sec_wrap,
    output logic o_low_half
);

    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
    localparam logic [W-1:0] HALF = W'(CLK_DIV / 2);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (o_sec_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_sec_wrap = (r_count == LAST);
    assign o_low_half = (r_count < HALF);

endmodule

// File: rtl/clock_set_controller.sv
// rtl/clock_set_controller.sv - one-second tick generation and button-driven time set FSM
module clock_set_controller
    import clock_pkg::*;
#(
    parameter int CLK_DIV   = 50000000,
    parameter int TIMEOUT_S = 30
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_mode_btn,
    input  logic       i_inc_btn,
    input  logic [5:0] i_cur_seconds,
    input  logic [5:0] i_cur_minutes,
    input  logic [5:0] i_cur_hours,
    output logic       o_tick_en,
    output logic       o_load,
    output logic [5:0] o_set_seconds,
    output logic [5:0] o_set_minutes,
    output logic [5:0] o_set_hours,
    output logic [1:0] o_field_sel,
    output logic       o_blink
);

    localparam logic [5:0] TIMEOUT_V = 6'(TIMEOUT_S);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_mode_q;
    logic       r_inc_q;
    logic [5:0] r_timeout_cnt;
    logic       w_mode_p;
    logic       w_inc_p;
    logic       w_timeout;
    logic       w_load_next;
    logic       w_sec_wrap;
    logic       w_low_half;

    assign w_mode_p    = i_mode_btn & ~r_mode_q;
    assign w_inc_p     = i_inc_btn & ~r_inc_q;
    assign w_load_next = (r_state == ST_SET_S) && w_mode_p;

    // Clearing on the load edge makes the first tick after a set land a full second later.
    tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (w_load_next),
        .o_sec_wrap (w_sec_wrap),
        .o_low_half (w_low_half)
    );

    always_comb begin
        w_state_next = r_state;
        w_timeout    = (r_state != ST_RUN) && (r_timeout_cnt == TIMEOUT_V);
        case (r_state)
            ST_RUN:   if (w_mode_p) w_state_next = ST_SET_H;
            ST_SET_H: if (w_mode_p) w_state_next = ST_SET_M; else if (w_timeout) w_state_next = ST_RUN;
            ST_SET_M: if (w_mode_p) w_state_next = ST_SET_S; else if (w_timeout) w_state_next = ST_RUN;
            ST_SET_S: if (w_mode_p || w_timeout) w_state_next = ST_RUN;
            default:  w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_RUN;
            r_mode_q  <= 1'b0;
            r_inc_q   <= 1'b0;
            o_tick_en <= 1'b0;
            o_load    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_mode_q  <= i_mode_btn;
            r_inc_q   <= i_inc_btn;
            o_tick_en <= w_sec_wrap && (r_state == ST_RUN);
            o_load    <= w_load_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || r_state == ST_RUN || w_state_next == ST_RUN || w_mode_p || w_inc_p) begin
            r_timeout_cnt <= 6'd0;
        end else if (w_sec_wrap) begin
            r_timeout_cnt <= r_timeout_cnt + 6'd1;
        end
    end

    // Mode and timeout both take priority over an increment in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_set_hours   <= 6'd0;
            o_set_minutes <= 6'd0;
            o_set_seconds <= 6'd0;
        end else if (r_state == ST_RUN) begin
            if (w_mode_p) begin
                o_set_hours   <= i_cur_hours;
                o_set_minutes <= i_cur_minutes;
                o_set_seconds <= i_cur_seconds;
            end
        end else if (w_inc_p && !w_mode_p && !w_timeout) begin
            case (r_state)
                ST_SET_H: o_set_hours   <= wrap_inc(o_set_hours, HOUR_MAX);
                ST_SET_M: o_set_minutes <= wrap_inc(o_set_minutes, MIN_MAX);
                ST_SET_S: o_set_seconds <= wrap_inc(o_set_seconds, SEC_MAX);
                default:  ;
            endcase
        end
    end

    always_comb begin
        o_field_sel = FIELD_NONE;
        case (r_state)
            ST_SET_H: o_field_sel = FIELD_HOURS;
            ST_SET_M: o_field_sel = FIELD_MINUTES;
            ST_SET_S: o_field_sel = FIELD_SECONDS;
            default:  o_field_sel = FIELD_NONE;
        endcase
    end

    assign o_blink = (r_state != ST_RUN) && w_low_half;

endmodule

// File: tb/tb_clock_set_controller.sv
// tb/tb_clock_set_controller.sv - self-checking bench for clock_set_controller
module tb_clock_set_controller;

    localparam int DIV  = 4;
    localparam int TOUT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [5:0] cur_s = 6'd0;
    logic [5:0] cur_m = 6'd0;
    logic [5:0] cur_h = 6'd0;
    logic       tick_en;
    logic       load;
    logic [5:0] set_s;
    logic [5:0] set_m;
    logic [5:0] set_h;
    logic [1:0] field_sel;
    logic       blink;

    always #5 clk = ~clk;

    clock_set_controller #(.CLK_DIV(DIV), .TIMEOUT_S(TOUT)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_mode_btn    (mode_btn),
        .i_inc_btn     (inc_btn),
        .i_cur_seconds (cur_s),
        .i_cur_minutes (cur_m),
        .i_cur_hours   (cur_h),
        .o_tick_en     (tick_en),
        .o_load        (load),
        .o_set_seconds (set_s),
        .o_set_minutes (set_m),
        .o_set_hours   (set_h),
        .o_field_sel   (field_sel),
        .o_blink       (blink)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: fields as integers, advanced with modular arithmetic.
    int  m_field;
    int  m_presc;
    int  m_tout;
    int  m_set[3];
    int  lim[3] = '{24, 60, 60};
    bit  m_tick, m_load, m_pm, m_pi, m_valid = 1'b0;
    bit  mp, ip, wrap, timed;

    always @(posedge clk) begin
        if (reset) begin
            m_field = 0; m_presc = 0; m_tout = 0; m_set = '{0, 0, 0};
            m_tick = 0; m_load = 0; m_pm = 0; m_pi = 0; m_valid = 1;
        end else begin
            mp     = mode_btn && !m_pm;
            ip     = inc_btn && !m_pi;
            wrap   = (m_presc == DIV - 1);
            timed  = (m_field != 0) && (m_tout >= TOUT);
            m_tick = (m_field == 0) && wrap;
            m_load = (m_field == 3) && mp;
            if (mp) begin
                if (m_field == 0) m_set = '{int'(cur_h), int'(cur_m), int'(cur_s)};
                m_field = (m_field + 1) % 4;
                m_tout  = 0;
            end else if (timed) begin
                m_field = 0;
                m_tout  = 0;
            end else if (m_field != 0) begin
                if (ip) begin
                    m_set[m_field-1] = (m_set[m_field-1] + 1) % lim[m_field-1];
                    m_tout = 0;
                end else if (wrap) begin
                    m_tout++;
                end
            end
            m_presc = m_load ? 0 : (m_presc + 1) % DIV;
            m_pm = mode_btn;
            m_pi = inc_btn;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("m_tick_en", tick_en, m_tick);
            check("m_load", load, m_load);
            check("m_set_hours", set_h, m_set[0]);
            check("m_set_minutes", set_m, m_set[1]);
            check("m_set_seconds", set_s, m_set[2]);
            check("m_field_sel", field_sel, m_field);
            check("m_blink", blink, (m_field != 0) && (m_presc < DIV / 2));
        end
    end

    int          load_cnt = 0;
    logic [17:0] load_val = '0;

    always @(negedge clk) begin
        if (load === 1'b1) begin
            load_cnt++;
            load_val = {set_h, set_m, set_s};
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic press_mode();
        mode_btn = 1'b1; step(1);
        mode_btn = 1'b0; step(1);
    endtask

    task automatic press_inc();
        inc_btn = 1'b1; step(1);
        inc_btn = 1'b0; step(1);
    endtask

    task automatic tick_run(input int n, input string nm);
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            #1;
            check(nm, tick_en, (c % 4 == 0));
        end
    endtask

    initial begin
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        tick_run(12, "free_tick");
        check("free_load", load_cnt, 0);

        cur_h = 6'd23; cur_m = 6'd59; cur_s = 6'd58;
        step(1);
        load_cnt = 0;
        press_mode();
        check("wrap_field_h", field_sel, 1);
        press_inc();
        press_mode();
        check("wrap_field_m", field_sel, 2);
        repeat (2) press_inc();
        press_mode();
        check("wrap_field_s", field_sel, 3);
        repeat (3) press_inc();
        press_mode();
        check("wrap_field_run", field_sel, 0);
        check("wrap_load_cnt", load_cnt, 1);
        check("wrap_load_val", load_val, {6'd0, 6'd1, 6'd1});

        cur_h = 6'd10; cur_m = 6'd20; cur_s = 6'd30;
        load_cnt = 0;
        press_mode();
        press_mode();
        mode_btn = 1'b1; inc_btn = 1'b1; step(1);
        mode_btn = 1'b0; inc_btn = 1'b0; step(1);
        check("simul_field", field_sel, 3);
        check("simul_minutes", set_m, 20);
        press_mode();
        check("simul_load_val", load_val, {6'd10, 6'd20, 6'd30});

        load_cnt = 0;
        press_mode();
        press_inc();
        check("tout_hours", set_h, 11);
        step(14);
        check("tout_field", field_sel, 0);
        check("tout_load_cnt", load_cnt, 0);

        cur_h = 6'd5;
        step(1);
        press_mode();
        inc_btn = 1'b1; step(10);
        inc_btn = 1'b0; step(1);
        check("held_hours", set_h, 6);

        reset = 1'b1; step(2);
        reset = 1'b0; step(1);
        cur_h = 6'd12; cur_m = 6'd34; cur_s = 6'd56;
        load_cnt = 0;
        repeat (3) press_mode();
        check("rst_pre_field", field_sel, 3);
        reset = 1'b1; step(1);
        check("rst_tick", tick_en, 0);
        check("rst_load", load, 0);
        check("rst_set", {set_h, set_m, set_s}, 0);
        check("rst_field", field_sel, 0);
        check("rst_blink", blink, 0);
        reset = 1'b0;
        tick_run(4, "rst_resume_tick");
        check("rst_load_cnt", load_cnt, 0);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
